// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file with busy scoreboard.
//   NRD combinational read ports, NWR write ports (higher index wins on collision),
//   optional hardwired-zero register 0 and optional same-cycle write-to-read bypass.
//   A per-register busy bit tracks one in-flight producer.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rd_addr/rd_data     read ports, port i at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W]
//   rd_busy             per read port: addressed register has a pending producer
//   wr_en/addr/data     write ports, port j packed the same way
//   issue_en/addr       mark a destination register busy at the next edge

// One read port: stored value/busy, optionally overridden by a same-cycle write.
module regfile_mp_rdport #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = $clog2(NREGS)
) (
    input  logic                               rst,
    input  logic [ADDR_W-1:0]                  addr,
    input  logic [NREGS-1:0][DATA_W-1:0]       regs,
    input  logic [NREGS-1:0]                   busy,
    input  logic [NWR-1:0]                     wr_en,
    input  logic [NWR-1:0][ADDR_W-1:0]         wr_addr,
    input  logic [NWR-1:0][DATA_W-1:0]         wr_data,
    output logic [DATA_W-1:0]                  rdata,
    output logic                               rbusy
);
    logic              hit;
    logic [DATA_W-1:0] hdat;

    always_comb begin
        hit  = 1'b0;
        hdat = '0;
        // Ascending scan: the last match is the highest-index port, same as the write.
        for (int j = 0; j < NWR; j++) begin
            if (wr_en[j] && wr_addr[j] == addr) begin
                hit  = 1'b1;
                hdat = wr_data[j];
            end
        end

        rdata = regs[addr];
        rbusy = busy[addr];
        // A forwarded value is by definition available, so busy drops with it.
        if (BYPASS != 0 && hit) begin
            rdata = hdat;
            rbusy = 1'b0;
        end
        if (ZERO_REG != 0 && addr == '0) begin
            rdata = '0;
            rbusy = 1'b0;
        end
        if (rst) begin
            rdata = '0;
            rbusy = 1'b0;
        end
    end
endmodule

module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int ADDR_W  = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic                    issue_en,
    input  logic [ADDR_W-1:0]       issue_addr
);
    logic [NREGS-1:0][DATA_W-1:0] regs;
    logic [NREGS-1:0]             busy;

    logic [NWR-1:0][ADDR_W-1:0]   wa;
    logic [NWR-1:0][DATA_W-1:0]   wd;
    assign wa = wr_addr;
    assign wd = wr_data;

    // Per-register resolved write enable/data and issue strobe.
    logic [NREGS-1:0]             wen_r;
    logic [NREGS-1:0][DATA_W-1:0] wdat_r;
    logic [NREGS-1:0]             iss_r;

    always_comb begin
        wen_r  = '0;
        wdat_r = '0;
        iss_r  = '0;
        for (int r = 0; r < NREGS; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wa[j] == ADDR_W'(r)) begin
                    wen_r[r]  = 1'b1;
                    wdat_r[r] = wd[j];
                end
            end
            iss_r[r] = issue_en && issue_addr == ADDR_W'(r);
        end
        // Register 0 is constant: drop its writes and never let it go busy.
        if (ZERO_REG != 0) begin
            wen_r[0] = 1'b0;
            iss_r[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (wen_r[r])
                    regs[r] <= wdat_r[r];
                // Issue wins over a same-cycle write: it names a newer producer.
                if (iss_r[r])
                    busy[r] <= 1'b1;
                else if (wen_r[r])
                    busy[r] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        regfile_mp_rdport #(
            .DATA_W   (DATA_W),
            .NREGS    (NREGS),
            .NWR      (NWR),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG),
            .ADDR_W   (ADDR_W)
        ) u_rd (
            .rst     (rst),
            .addr    (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs    (regs),
            .busy    (busy),
            .wr_en   (wr_en),
            .wr_addr (wa),
            .wr_data (wd),
            .rdata   (rd_data[i*DATA_W +: DATA_W]),
            .rbusy   (rd_busy[i])
        );
    end
endmodule
